fetch_exec_unit: RTL and testbench
==================================

Name: fetch_exec_unit

Overview:
Instruction sequencer for the 4-bit datapath. It sits between the 12-bit loadable program counter/8-bit program ROM and the 4-bit ALU. It latches each ROM byte into an instruction register, steps or loads the PC, and drives ALU A/B/sel. It holds the accumulator, zero flag and output port, and handles 2-byte jump instructions.

Parameters:
IR_RESET, 8'h90, instruction register value at reset (NOP encoding)
HALT_OPC, 4'hF, opcode that halts the sequencer

Ports:
CLK  in  1  single system clock, rising edge
RESET_N  in  1  asynchronous, active-low reset; clears all state immediately
RUN  in  1  high = allowed to leave FETCH; low = hold in FETCH
ROM_D  in  8  program byte at current PC (combinational ROM)
PC_EN  out  1  counter increment enable
PC_LOAD  out  1  counter load strobe; direct flop output, glitch-free (counter treats load as asynchronous)
PC_D  out  12  counter load value; direct flop output
ALU_A  out  4  = ACC
ALU_B  out  4  = IR[3:0]
ALU_SEL  out  3  = IR[6:4]
ALU_Y  in  4  ALU result
ACC  out  4  accumulator
ZF  out  1  zero flag
OUT_DATA  out  4  output port value
OUT_VALID  out  1  one-cycle strobe on OUT_DATA update
HALTED  out  1  high in HALT state

Behaviour:
- Reset (RESET_N=0, async): state=FETCH, IR=IR_RESET, ACC=0, ZF=0, OUT_DATA=0, OUT_VALID=0, PC_LOAD=0, PC_D=0, HALTED=0, PC_EN=0. The top level derives the counter's active-high reset from RESET_N.
- Instruction byte = {opc[7:4], opr[3:0]}.
  - opc 0x0-0x7: ACC<=ALU_Y; ZF<=(ALU_Y==0).
  - 0x8 LDI: ACC<=opr; ZF<=(opr==0).
  - 0x9 NOP.
  - 0xA JMP: 2-byte; target = {opr, next byte}.
  - 0xB JZ: 2-byte; jump only if ZF=1.
  - 0xC OUT: OUT_DATA<=ACC, OUT_VALID pulse.
  - HALT_OPC: halt.
  - All other opcodes: NOP.
- States:
  - FETCH: PC_EN=RUN. If RUN=1: IR<=ROM_D, go EXEC. If RUN=0: hold, IR unchanged.
  - EXEC: apply IR effect at the rising edge ending the cycle.
    - ALU/LDI/NOP/OUT -> FETCH.
    - JMP, or JZ with ZF=1: PC_EN=1 (consumes second byte); PC_D<={IR[3:0],ROM_D}; PC_LOAD<=1; -> JUMP.
    - JZ with ZF=0: PC_EN=1 (skips second byte), no load, -> FETCH.
    - HALT_OPC -> HALT.
  - JUMP: PC_LOAD=1 for the whole cycle, PC_EN=0. At the end of the cycle PC_LOAD<=0, -> FETCH.
  - HALT: HALTED=1, PC_EN=0, PC_LOAD=0. Exit only via reset.
- PC_EN is asserted only in FETCH(RUN=1), and in EXEC for JMP/JZ. Never asserted together with PC_LOAD=1.
- Latency in clocks: 2 for single-byte instructions, 2 for JZ not taken, 3 for JMP/JZ taken.
- ALU outputs are combinational from ACC/IR. The ALU result is sampled only in EXEC.
- 4-bit arithmetic wraps. ACC takes ALU_Y as-is and has no carry/borrow flag.
- OUT_VALID is registered: high exactly for the cycle after the OUT EXEC edge. OUT_DATA holds until the next OUT.
- RUN gates only the FETCH->EXEC transition. An instruction already in EXEC/JUMP always completes.
- Reset mid-JUMP: PC_LOAD drops to 0 asynchronously with RESET_N.
- ZF is unchanged by JMP/JZ/OUT/NOP.

Test Plan:
1. RESET_N=0 for 2 clocks with RUN=1 -> ACC=0, ZF=0, PC_EN=0, PC_LOAD=0, OUT_VALID=0, HALTED=0. Release -> PC_EN=1 in the first FETCH.
2. ROM 0x85, 0x23; bench ALU returns 8 -> after LDI, ACC=5. Add EXEC shows ALU_A=5, ALU_B=3, ALU_SEL=2. Then ACC=8, ZF=0, with 4 clocks and 2 PC_EN pulses total.
3. ACC=2, byte 0x63, ALU_Y=0xF -> ACC=0xF, ZF=0. Then 0x30 with ALU_Y=0 -> ACC=0, ZF=1.
4. Bytes 0xA1, 0x23 -> EXEC has PC_EN=1. JUMP has PC_LOAD=1, PC_D=0x123, PC_EN=0. FETCH follows with PC_LOAD=0, 3 clocks total.
5. JZ 0xB4, 0x56 with ZF=0 -> no PC_LOAD, 2 clocks, PC advanced by 2. With ZF=1 -> PC_LOAD pulse, PC_D=0x456.
6. ACC=9, byte 0xC0 -> OUT_DATA=9, OUT_VALID high for 1 cycle. RUN=0 in FETCH -> PC_EN=0, IR held. Byte 0xF0 -> HALTED=1, PC_EN stays 0 for 20 clocks until RESET_N=0.

Source files
------------

// File: rtl/fetch_exec_unit.sv
// fetch_exec_unit: instruction sequencer for the 4-bit datapath.
// It fetches ROM bytes into IR and steps or loads the external PC.
// It drives the ALU operands and holds ACC, ZF and the output port.
module fetch_exec_unit #(
  parameter logic [7:0] IR_RESET = 8'h90,
  parameter logic [3:0] HALT_OPC = 4'hF
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        RUN,
  input  logic [7:0]  ROM_D,
  output logic        PC_EN,
  output logic        PC_LOAD,
  output logic [11:0] PC_D,
  output logic [3:0]  ALU_A,
  output logic [3:0]  ALU_B,
  output logic [2:0]  ALU_SEL,
  input  logic [3:0]  ALU_Y,
  output logic [3:0]  ACC,
  output logic        ZF,
  output logic [3:0]  OUT_DATA,
  output logic        OUT_VALID,
  output logic        HALTED
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_JUMP  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [3:0] OPC_LDI = 4'h8;
  localparam logic [3:0] OPC_JMP = 4'hA;
  localparam logic [3:0] OPC_JZ  = 4'hB;
  localparam logic [3:0] OPC_OUT = 4'hC;

  logic [1:0] state;
  logic [7:0] ir;
  logic [3:0] acc, out_data;
  logic       zf, out_valid, pc_load;
  logic [11:0] pc_d;

  logic [3:0] opc, opr;
  logic       is_halt, is_branch, br_take, in_exec;

  assign opc       = ir[7:4];
  assign opr       = ir[3:0];
  assign in_exec   = (state == S_EXEC);
  assign is_halt   = (opc == HALT_OPC);
  // Both branch forms consume the second byte, taken or not.
  assign is_branch = !is_halt && (opc == OPC_JMP || opc == OPC_JZ);
  assign br_take   = (opc == OPC_JMP) || (opc == OPC_JZ && zf);

  // PC step: FETCH when allowed to run, or EXEC stepping over a branch operand.
  // Gated by RESET_N so the counter never steps while reset is held.
  always_comb begin
    PC_EN = 1'b0;
    if (RESET_N) begin
      if (state == S_FETCH) PC_EN = RUN;
      else if (in_exec)     PC_EN = is_branch;
    end
  end

  // Sequencer state, IR, and the registered PC load strobe/value.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_FETCH;
      ir      <= IR_RESET;
      pc_load <= 1'b0;
      pc_d    <= '0;
    end else begin
      case (state)
        S_FETCH: if (RUN) begin
          ir    <= ROM_D;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (is_halt) begin
            state <= S_HALT;
          end else if (is_branch && br_take) begin
            pc_d    <= {opr, ROM_D};
            pc_load <= 1'b1;
            state   <= S_JUMP;
          end else begin
            state <= S_FETCH;
          end
        end
        S_JUMP: begin
          pc_load <= 1'b0;
          state   <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // Datapath effects, applied on the edge that ends EXEC.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      acc       <= '0;
      zf        <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_exec && !is_halt) begin
        if (!opc[3]) begin
          acc <= ALU_Y;
          zf  <= (ALU_Y == 4'd0);
        end else if (opc == OPC_LDI) begin
          acc <= opr;
          zf  <= (opr == 4'd0);
        end else if (opc == OPC_OUT) begin
          out_data  <= acc;
          out_valid <= 1'b1;
        end
      end
    end
  end

  assign ALU_A     = acc;
  assign ALU_B     = opr;
  assign ALU_SEL   = ir[6:4];
  assign ACC       = acc;
  assign ZF        = zf;
  assign OUT_DATA  = out_data;
  assign OUT_VALID = out_valid;
  assign PC_LOAD   = pc_load;
  assign PC_D      = pc_d;
  assign HALTED    = (state == S_HALT);

endmodule

// File: tb/tb_fetch_exec_unit.sv
// Bench for fetch_exec_unit: a counter model and a program ROM wrapped
// around the DUT. ALU results are driven by hand for each step.
module tb_fetch_exec_unit;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        RUN = 1'b1;
  logic [7:0]  ROM_D;
  logic        PC_EN, PC_LOAD, ZF, OUT_VALID, HALTED;
  logic [11:0] PC_D;
  logic [3:0]  ALU_A, ALU_B, ALU_Y, ACC, OUT_DATA;
  logic [2:0]  ALU_SEL;

  logic [7:0]  rom [0:4095];
  logic [11:0] pc;
  int          errs = 0, checks = 0;
  int          en_cnt = 0, ld_cnt = 0;
  bit          hit;

  fetch_exec_unit dut (
    .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN), .ROM_D(ROM_D),
    .PC_EN(PC_EN), .PC_LOAD(PC_LOAD), .PC_D(PC_D),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_SEL(ALU_SEL), .ALU_Y(ALU_Y),
    .ACC(ACC), .ZF(ZF), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  // 12-bit counter model: load wins over increment.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)     pc <= '0;
    else if (PC_LOAD) pc <= PC_D;
    else if (PC_EN)   pc <= pc + 12'd1;
  end

  assign ROM_D = rom[pc];

  // Per-cycle strobe counters.
  always @(posedge CLK) begin
    if (PC_EN)   en_cnt++;
    if (PC_LOAD) ld_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h90;
    rom[12'h000] = 8'h85; // LDI 5
    rom[12'h001] = 8'h23; // ALU sel 2, B=3
    rom[12'h002] = 8'h82; // LDI 2
    rom[12'h003] = 8'h63; // ALU sel 6, B=3
    rom[12'h004] = 8'h30; // ALU sel 3, B=0
    rom[12'h005] = 8'hA1; // JMP 0x123
    rom[12'h006] = 8'h23;
    rom[12'h123] = 8'hB4; // JZ 0x456 (ZF=1, taken)
    rom[12'h124] = 8'h56;
    rom[12'h456] = 8'h81; // LDI 1
    rom[12'h457] = 8'hB4; // JZ (ZF=0, not taken)
    rom[12'h458] = 8'h56;
    rom[12'h459] = 8'h89; // LDI 9
    rom[12'h45A] = 8'hC0; // OUT
    rom[12'h45B] = 8'hF0; // HALT
    ALU_Y = 4'h8;

    // Reset held for two clocks with RUN high.
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    chk("rst_acc", ACC, 0);
    chk("rst_zf", ZF, 0);
    chk("rst_pc_en", PC_EN, 0);
    chk("rst_pc_load", PC_LOAD, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_halted", HALTED, 0);
    chk("rst_alu_b", ALU_B, 0);   // IR = 0x90
    RESET_N = 1'b1;
    #1;
    chk("fetch0_pc_en", PC_EN, 1);
    en_cnt = 0;

    // LDI 5 then ALU op 2 with B=3; bench ALU returns 8.
    clk(2);
    chk("ldi_acc", ACC, 5);
    clk(1);
    chk("add_alu_a", ALU_A, 5);
    chk("add_alu_b", ALU_B, 3);
    chk("add_alu_sel", ALU_SEL, 2);
    clk(1);
    chk("add_acc", ACC, 8);
    chk("add_zf", ZF, 0);
    chk("add_en_pulses", en_cnt, 2);

    // LDI 2, ALU op -> 0xF, ALU op -> 0 sets ZF.
    clk(2);
    chk("ldi2_acc", ACC, 2);
    ALU_Y = 4'hF;
    clk(2);
    chk("alu_f_acc", ACC, 4'hF);
    chk("alu_f_zf", ZF, 0);
    ALU_Y = 4'h0;
    clk(2);
    chk("alu_0_acc", ACC, 0);
    chk("alu_0_zf", ZF, 1);

    // JMP 0x123: EXEC steps PC, JUMP loads, FETCH follows.
    clk(1);
    chk("jmp_exec_pc_en", PC_EN, 1);
    chk("jmp_exec_pc_load", PC_LOAD, 0);
    clk(1);
    chk("jmp_jump_pc_load", PC_LOAD, 1);
    chk("jmp_jump_pc_d", PC_D, 12'h123);
    chk("jmp_jump_pc_en", PC_EN, 0);
    clk(1);
    chk("jmp_fetch_pc_load", PC_LOAD, 0);
    chk("jmp_fetch_pc", pc, 12'h123);
    chk("jmp_fetch_pc_en", PC_EN, 1);

    // JZ taken (ZF still 1 across JMP).
    clk(1);
    chk("jz_t_exec_pc_en", PC_EN, 1);
    clk(1);
    chk("jz_t_pc_load", PC_LOAD, 1);
    chk("jz_t_pc_d", PC_D, 12'h456);
    clk(1);
    chk("jz_t_pc", pc, 12'h456);

    // LDI 1 clears ZF, then JZ not taken: 2 clocks, PC +2, no load.
    clk(2);
    chk("ldi1_zf", ZF, 0);
    ld_cnt = 0;
    clk(2);
    chk("jz_nt_pc", pc, 12'h459);
    chk("jz_nt_loads", ld_cnt, 0);
    chk("jz_nt_pc_en", PC_EN, 1);

    // LDI 9, OUT.
    clk(2);
    chk("ldi9_acc", ACC, 9);
    clk(2);
    chk("out_valid_hi", OUT_VALID, 1);
    chk("out_data", OUT_DATA, 9);

    // RUN low holds FETCH with IR unchanged.
    RUN = 1'b0;
    #1;
    chk("hold_pc_en", PC_EN, 0);
    clk(2);
    chk("out_valid_lo", OUT_VALID, 0);
    chk("hold_alu_sel", ALU_SEL, 4);
    chk("hold_pc", pc, 12'h45B);
    chk("hold_halted", HALTED, 0);
    RUN = 1'b1;

    // HALT: stays halted with PC_EN low.
    clk(2);
    chk("halt_halted", HALTED, 1);
    en_cnt = 0;
    clk(20);
    chk("halt_en_cnt", en_cnt, 0);
    chk("halt_still", HALTED, 1);
    chk("halt_out_data", OUT_DATA, 9);
    RESET_N = 1'b0;
    #1;
    chk("halt_rst_halted", HALTED, 0);
    chk("halt_rst_out_data", OUT_DATA, 0);

    // Reset while in JUMP drops PC_LOAD immediately.
    clk(1);
    RESET_N = 1'b1;
    ALU_Y = 4'h0;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      clk(1);
      if (PC_LOAD) hit = 1'b1;
    end
    chk("midjump_reached", hit, 1);
    RESET_N = 1'b0;
    #1;
    chk("midjump_pc_load", PC_LOAD, 0);
    chk("midjump_pc_d", PC_D, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
